// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one FIFO write port between NUM_PORTS
// block writers. A port owns the FIFO for one burst, which ends on its
// s_last transfer or after MAX_BURST words, whichever comes first.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   s_valid     - per-port word valid
//   s_data      - per-port word, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_last      - per-port final word of block (qualified by s_valid)
//   s_ready     - per-port accept (valid & ready = transfer)
//   fifo_din    - granted port's data while busy, 0 when idle
//   fifo_wr_en  - FIFO write strobe, never high while fifo_full
//   fifo_full   - FIFO full flag
//   grant       - one-hot current owner, 0 when idle
//   busy        - burst in progress
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; pick next requester after last_port (with wrap)
// BURST | owner in grant_q connected to FIFO until last/MAX_BURST
module fifo_wr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_PORTS-1:0]            s_last,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]           fifo_din,
    output logic                            fifo_wr_en,
    input  logic                            fifo_full,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [PW-1:0]        last_port_q, last_port_d;
    logic [CW-1:0]        burst_cnt_q, burst_cnt_d;

    logic [PW-1:0]        pick;
    logic                 pick_vld;
    logic                 g_valid;
    logic                 g_last;
    logic                 xfer;
    logic                 burst_end;
    logic [CW-1:0]        cnt_inc;

    // Search upward from last_port+1 with wrap, so the port that just
    // finished a burst is visited last.
    always_comb begin : arb_search
        int            idx_i;
        logic [PW-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx_i    = 0;
        idx      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx_i = (int'(last_port_q) + k) % NUM_PORTS;
            idx   = PW'(idx_i);
            if (!pick_vld && s_valid[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // grant_q is zero outside BURST, so these masks are inert when idle.
    always_comb begin
        g_valid   = |(s_valid & grant_q);
        g_last    = |(s_last & grant_q);
        xfer      = (state_q == BURST) && g_valid && !fifo_full;
        cnt_inc   = burst_cnt_q + CW'(1);
        // s_last and the count limit on the same transfer is one end event.
        burst_end = xfer && (g_last || (cnt_inc == CW'(MAX_BURST)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_port_q <= PW'(NUM_PORTS - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            last_port_q <= last_port_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_port_d = last_port_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BURST;
                    grant_d = NUM_PORTS'(1) << pick;
                    gidx_d  = pick;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    last_port_d = gidx_q;
                    burst_cnt_d = '0;
                end else if (xfer) begin
                    burst_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == BURST);
        grant      = grant_q;
        s_ready    = grant_q & {NUM_PORTS{busy && !fifo_full}};
        fifo_wr_en = xfer;
        fifo_din   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                fifo_din = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a vector table for the single-port case,
// directed multi-cycle sequences, and randomized traffic checked against a
// behavioural per-cycle model. A behavioural FWFT FIFO (16 deep) with a
// randomly pacing reader closes the loop end to end.
module tb_fifo_wr_arbiter;

    localparam int NP     = 4;
    localparam int DW     = 16;
    localparam int MB     = 16;
    localparam int FDEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NP-1:0]     s_valid = '0;
    logic [NP*DW-1:0]  s_data = '0;
    logic [NP-1:0]     s_last = '0;
    logic [NP-1:0]     s_ready;
    logic [DW-1:0]     fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full = 1'b0;
    logic [NP-1:0]     grant;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .fifo_din  (fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full (fifo_full),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- producers, FIFO and reference model ----------------
    logic [DW:0]   pq [NP][$];      // {last, data} pending per port
    int            seq [NP];
    logic [DW-1:0] lane [NP];
    logic [NP-1:0] stall_m = '0;
    logic          force_full = 1'b0;
    int            rd_pct = 100;
    logic [DW-1:0] fq[$];           // FIFO contents from DUT writes
    logic [DW-1:0] xq[$];           // FIFO contents the model expects
    logic [DW-1:0] wlog[$];         // DUT write log for the current test
    logic [DW-1:0] el[$];           // expected write order for the test
    int            m_own = -1;
    int            m_last = NP - 1;
    int            m_cnt = 0;

    task automatic add_block(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            pq[p].push_back({(i == len - 1), 4'(p), 12'(seq[p])});
            seq[p]++;
        end
    endtask

    task automatic add_exp(input int p, input int from, input int to);
        for (int i = from; i <= to; i++) el.push_back({4'(p), 12'(i)});
    endtask

    task automatic new_test();
        wlog.delete();
        el.delete();
        for (int p = 0; p < NP; p++) seq[p] = 0;
    endtask

    task automatic drive();
        logic [DW:0] h;
        for (int p = 0; p < NP; p++) begin
            if (pq[p].size() > 0 && !stall_m[p]) begin
                h          = pq[p][0];
                s_valid[p] = 1'b1;
                s_last[p]  = h[DW];
                lane[p]    = h[DW-1:0];
            end else begin
                s_valid[p] = 1'b0;
                s_last[p]  = 1'b0;
                lane[p]    = '0;
            end
            s_data[p*DW +: DW] = lane[p];
        end
        fifo_full = force_full || (fq.size() >= FDEPTH);
    endtask

    // Called mid-cycle: compare outputs against the model, then advance the
    // model, producers and FIFO as of the coming edge.
    task automatic check_adv();
        logic [NP-1:0] eg, er;
        logic          ew, eb;
        logic [DW-1:0] ed, r;
        logic [DW:0]   h;
        eb = (m_own >= 0);
        eg = '0;
        er = '0;
        ew = 1'b0;
        ed = '0;
        if (eb) begin
            eg = NP'(1) << m_own;
            er = fifo_full ? '0 : eg;
            ew = s_valid[2'(m_own)] && !fifo_full;
            ed = lane[m_own];
        end
        chk("grant", grant, eg);
        chk("busy", busy, eb);
        chk("s_ready", s_ready, er);
        chk("fifo_wr_en", fifo_wr_en, ew);
        chk("fifo_din", fifo_din, ed);

        if (fq.size() > 0 && $urandom_range(99) < rd_pct) begin
            r = fq.pop_front();
            if (xq.size() == 0) fail("fifo_rd_unexpected");
            else chk("fifo_rd", r, xq.pop_front());
        end
        if (fifo_wr_en) begin
            fq.push_back(fifo_din);
            wlog.push_back(fifo_din);
        end

        if (!eb) begin
            for (int k = 1; k <= NP; k++) begin
                if (s_valid[2'((m_last + k) % NP)]) begin
                    m_own = (m_last + k) % NP;
                    break;
                end
            end
        end else if (ew) begin
            h = pq[m_own].pop_front();
            xq.push_back(h[DW-1:0]);
            m_cnt++;
            if (h[DW] || m_cnt == MB) begin
                m_last = m_own;
                m_own  = -1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int maxc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            done = (m_own < 0);
            for (int p = 0; p < NP; p++) if (pq[p].size() > 0) done = 1'b0;
            if (done) break;
            cycle();
        end
        if (!done) fail("timeout_waiting_idle");
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, 64'(wlog.size()), 64'(el.size()));
        for (int i = 0; i < wlog.size() && i < el.size(); i++) chk(name, wlog[i], el[i]);
    endtask

    // Asserts reset without touching inputs first, so the immediate zero
    // outputs come from the asynchronous reset alone.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_ready", s_ready, '0);
        chk("rst_din", fifo_din, '0);
        s_valid    = '0;
        s_last     = '0;
        s_data     = '0;
        force_full = 1'b0;
        fifo_full  = 1'b0;
        stall_m    = '0;
        for (int p = 0; p < NP; p++) pq[p].delete();
        m_own  = -1;
        m_last = NP - 1;
        m_cnt  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table: single port 0 ----------------
    typedef struct {
        logic [NP-1:0] v;
        logic [NP-1:0] l;
        logic          f;
        logic [DW-1:0] d0;
        logic [NP-1:0] eg;
        logic [NP-1:0] er;
        logic          ew;
        logic [DW-1:0] ed;
        logic          eb;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic [15:0] d0, input logic [3:0] eg,
                                input logic [3:0] er, input logic ew,
                                input logic [15:0] ed, input logic eb);
        vec_t t;
        t.v = v; t.l = l; t.f = f; t.d0 = d0;
        t.eg = eg; t.er = er; t.ew = ew; t.ed = ed; t.eb = eb;
        return t;
    endfunction

    vec_t tv [13];

    initial begin
        tv[0]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
        tv[1]  = mk(4'h1, 4'h0, 1'b0, 16'h0001, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
        tv[2]  = mk(4'h1, 4'h0, 1'b0, 16'h0001, 4'h1, 4'h1, 1'b1, 16'h0001, 1'b1);
        tv[3]  = mk(4'h1, 4'h0, 1'b0, 16'h0002, 4'h1, 4'h1, 1'b1, 16'h0002, 1'b1);
        tv[4]  = mk(4'h1, 4'h0, 1'b1, 16'h0003, 4'h1, 4'h0, 1'b0, 16'h0003, 1'b1);
        tv[5]  = mk(4'h1, 4'h0, 1'b1, 16'h0003, 4'h1, 4'h0, 1'b0, 16'h0003, 1'b1);
        tv[6]  = mk(4'h1, 4'h0, 1'b0, 16'h0003, 4'h1, 4'h1, 1'b1, 16'h0003, 1'b1);
        tv[7]  = mk(4'h0, 4'h0, 1'b0, 16'h0004, 4'h1, 4'h1, 1'b0, 16'h0004, 1'b1);
        tv[8]  = mk(4'h1, 4'h0, 1'b0, 16'h0004, 4'h1, 4'h1, 1'b1, 16'h0004, 1'b1);
        tv[9]  = mk(4'h1, 4'h1, 1'b0, 16'h0005, 4'h1, 4'h1, 1'b1, 16'h0005, 1'b1);
        tv[10] = mk(4'h1, 4'h0, 1'b0, 16'h0006, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
        tv[11] = mk(4'h1, 4'h1, 1'b0, 16'h0006, 4'h1, 4'h1, 1'b1, 16'h0006, 1'b1);
        tv[12] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);

        #2;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            s_valid   = tv[i].v;
            s_last    = tv[i].l;
            fifo_full = tv[i].f;
            s_data    = {{(NP-1)*DW{1'b0}}, tv[i].d0};
            @(negedge clk);
            chk("tv_grant", grant, tv[i].eg);
            chk("tv_ready", s_ready, tv[i].er);
            chk("tv_wr_en", fifo_wr_en, tv[i].ew);
            chk("tv_din", fifo_din, tv[i].ed);
            chk("tv_busy", busy, tv[i].eb);
            @(posedge clk);
            #1;
        end

        do_reset();

        // Round robin: 3-word blocks on all ports, port 0 has a second block.
        new_test();
        add_block(0, 3); add_block(0, 3);
        add_block(1, 3); add_block(2, 3); add_block(3, 3);
        add_exp(0, 0, 2); add_exp(1, 0, 2); add_exp(2, 0, 2);
        add_exp(3, 0, 2); add_exp(0, 3, 5);
        run_until_idle(200);
        chk_log("rr_order");

        // Burst split at MAX_BURST with a competing short block.
        new_test();
        add_block(1, 40); add_block(2, 2);
        add_exp(1, 0, 15); add_exp(2, 0, 1); add_exp(1, 16, 31); add_exp(1, 32, 39);
        run_until_idle(300);
        chk_log("split_order");

        // s_last on exactly the MAX_BURST-th word: one burst end only.
        new_test();
        add_block(0, MB); add_block(0, 1);
        add_exp(0, 0, MB);
        run_until_idle(200);
        chk_log("last_at_max");

        // Source stall: port 3 owns, drops valid for 3 cycles, port 0 waits.
        new_test();
        add_block(3, 5);
        cycle();
        add_block(0, 2);
        cycle(); cycle();
        stall_m[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_grant", grant, 4'b1000);
        end
        stall_m[3] = 1'b0;
        add_exp(3, 0, 4); add_exp(0, 0, 1);
        run_until_idle(100);
        chk_log("stall_order");

        // Backpressure: full for 4 cycles in the middle of an 8-word burst.
        new_test();
        add_block(2, 8);
        cycle(); cycle(); cycle();
        force_full = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        force_full = 1'b0;
        add_exp(2, 0, 7);
        run_until_idle(100);
        chk_log("bp_order");

        // Reset after 2 of 6 words; the remainder is abandoned.
        new_test();
        add_block(1, 6);
        cycle(); cycle(); cycle();
        drive();
        #2;
        do_reset();
        add_block(2, 3); add_block(0, 3);
        add_exp(1, 0, 1); add_exp(0, 0, 2); add_exp(2, 0, 2);
        run_until_idle(100);
        chk_log("rst_order");

        // Randomized traffic, stalls, forced full and a slow reader.
        rd_pct = 55;
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() == 0 && $urandom_range(7) == 0)
                    add_block(p, int'($urandom_range(40, 1)));
                stall_m[p] = ($urandom_range(99) < 15);
            end
            force_full = ($urandom_range(99) < 10);
            cycle();
        end
        stall_m    = '0;
        force_full = 1'b0;
        rd_pct     = 100;
        run_until_idle(3000);
        for (int c = 0; c < 100 && fq.size() > 0; c++) cycle();
        chk("fifo_drained", 64'(fq.size()), 64'd0);
        chk("exp_drained", 64'(xq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
